// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: instruction
// encodings, FSM state encoding and operand-signedness helpers.
package muldiv_sequencer_pkg;

   localparam logic [6:0] FUNCT7_M  = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PREP   = 3'd1;
   localparam logic [2:0] ST_CALC   = 3'd2;
   localparam logic [2:0] ST_FIX    = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_PREP = ST_PREP,
      S_CALC = ST_CALC,
      S_FIX  = ST_FIX,
      S_DONE = ST_DONE
   } state_t;

   function automatic logic op_signed_a(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring divide step on the 2*XLEN accumulator.
module muldiv_iter_step #(
   parameter int XLEN = 32
) (
   input  logic                i_is_div,
   input  logic [2*XLEN-1:0]   i_acc,
   input  logic [XLEN-1:0]     i_opnd,
   output logic [2*XLEN-1:0]   o_acc
);

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shifted_hi;
   logic [XLEN-1:0] w_trial;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      o_acc        = i_acc;
      w_sum        = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd & {XLEN{i_acc[0]}}};
      w_shifted_hi = i_acc[2*XLEN-1:XLEN-1];
      // Partial remainder is always below the divisor, so the low XLEN bits hold the exact difference.
      w_trial      = w_shifted_hi[XLEN-1:0] - i_opnd;
      if (i_is_div) begin
         if (w_shifted_hi >= {1'b0, i_opnd})
            o_acc = {w_trial, i_acc[XLEN-2:0], 1'b1};
         else
            o_acc = {w_shifted_hi[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      end else begin
         o_acc = {w_sum, i_acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: accepts one op, iterates XLEN cycles on
// unsigned magnitudes, fixes signs, and returns a registered result.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_valid,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            req_ready,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int              CW      = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_funct3;
   logic              r_sign_a, r_sign_b;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_opnd;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_result;

   logic              w_is_div, w_div_zero, w_overflow, w_sign_a, w_sign_b;
   logic [XLEN-1:0]   w_abs_a, w_abs_b, w_orig_a, w_quot, w_rem;
   logic [XLEN-1:0]   w_special_result, w_fix_result;
   logic [2*XLEN-1:0] w_step_acc, w_prod;

   assign req_ready = (r_state == S_IDLE);
   assign done      = (r_state == S_DONE);
   assign stall     = req_valid & ~done;
   assign result    = r_result;

   assign w_sign_a  = op_signed_a(funct3) & op_a[XLEN-1];
   assign w_sign_b  = op_signed_b(funct3) & op_b[XLEN-1];
   assign w_abs_a   = w_sign_a ? -op_a : op_a;
   assign w_abs_b   = w_sign_b ? -op_b : op_b;

   assign w_is_div   = r_funct3[2];
   assign w_div_zero = w_is_div & (r_opnd == '0);
   assign w_overflow = w_is_div & r_sign_a & r_sign_b &
                       (r_acc[XLEN-1:0] == MIN_NEG) & (r_opnd == XLEN'(1));

   muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .i_is_div (w_is_div),
      .i_acc    (r_acc),
      .i_opnd   (r_opnd),
      .o_acc    (w_step_acc)
   );

   always_comb begin
      w_orig_a = r_sign_a ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
      if (w_div_zero)
         w_special_result = r_funct3[1] ? w_orig_a : '1;
      else
         w_special_result = r_funct3[1] ? '0 : MIN_NEG;

      w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
      w_quot = (r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
      w_rem  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
      case (r_funct3)
         F3_MUL:          w_fix_result = w_prod[XLEN-1:0];
         F3_DIV, F3_DIVU: w_fix_result = w_quot;
         F3_REM, F3_REMU: w_fix_result = w_rem;
         default:         w_fix_result = w_prod[2*XLEN-1:XLEN];
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_state_nxt = S_PREP;
         S_PREP:  w_state_nxt = (w_div_zero | w_overflow) ? S_DONE : S_CALC;
         S_CALC:  if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) w_state_nxt = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_funct3 <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (!flush) begin
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_funct3 <= funct3;
               r_sign_a <= w_sign_a;
               r_sign_b <= w_sign_b;
               // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
               r_acc    <= funct3[2] ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
               r_opnd   <= funct3[2] ? w_abs_b : w_abs_a;
            end
            S_PREP: begin
               if (w_div_zero | w_overflow) r_result <= w_special_result;
               else                         r_cnt    <= CW'(XLEN);
            end
            S_CALC: begin
               r_acc <= w_step_acc;
               r_cnt <= r_cnt - CW'(1);
            end
            S_FIX:   r_result <= w_fix_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases, special
// cases, back-to-back issue, flush/reset aborts and a randomized model run.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        flush = 1'b0;
   logic        req_ready, stall, done;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .funct3    (funct3),
      .op_a      (op_a),
      .op_b      (op_b),
      .flush     (flush),
      .req_ready (req_ready),
      .stall     (stall),
      .done      (done),
      .result    (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Architectural RV32M semantics computed with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint     sa = longint'($signed(a));
      longint     sb = longint'($signed(b));
      logic [63:0] ua = 64'(a);
      logic [63:0] ub = 64'(b);
      logic [63:0] p;
      case (f3)
         3'b000: begin p = ua * ub;                  return p[31:0];  end
         3'b001: begin p = 64'(sa * sb);             return p[63:32]; end
         3'b010: begin p = 64'(sa * longint'(ub));   return p[63:32]; end
         3'b011: begin p = ua * ub;                  return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'($signed(a) / $signed(b));
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bit is_div  = f3[2];
      bit sdiv    = (f3 == 3'b100) || (f3 == 3'b110);
      bit special = is_div && ((b == 0) || (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      return special ? 2 : 35;
   endfunction

   // Issue one op in the next cycle (expected IDLE) and wait for done.
   // Latency counts cycles after the accept edge, the done cycle included.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit keep,
                        output logic [31:0] res, output int lat, output bit stall_ok, output bit ready_ok);
      stall_ok = 1'b1;
      lat      = 999;
      res      = 'x;
      @(negedge clk);
      ready_ok  = (req_ready === 1'b1);
      req_valid = 1'b1;
      funct3    = f3;
      op_a      = a;
      op_b      = b;
      #1 if (stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      funct3 = 3'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = n;
            res = result;
            if (stall !== 1'b0) stall_ok = 1'b0;
            break;
         end
         if (stall !== 1'b1) stall_ok = 1'b0;
      end
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", result); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_mul();
      logic [31:0] res; int lat; bit s_ok, r_ok;
      do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, res, lat, s_ok, r_ok);
      checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
      checks++; if (lat != 35) begin errors++; $display("FAIL mul_latency got=%0d exp=35", lat); end
      checks++; if (!s_ok) begin errors++; $display("FAIL mul_stall got=bad exp=high for 35 cycles then low"); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || req_ready !== 1'b1)
         begin errors++; $display("FAIL mul_after_done got done=%b ready=%b exp done=0 ready=1", done, req_ready); end
   endtask

   task automatic test_mulh();
      logic [2:0]  f3s [3] = '{3'b001, 3'b011, 3'b010};
      logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] bs  [3] = '{32'h8000_0000, 32'h8000_0000, 32'd2};
      logic [31:0] exp [3] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
      logic [31:0] res; int lat; bit s_ok, r_ok;
      for (int i = 0; i < 3; i++) begin
         do_op(f3s[i], as[i], bs[i], 1'b0, res, lat, s_ok, r_ok);
         checks++; if (res !== exp[i]) begin errors++; $display("FAIL mulh_result[%0d] got=%h exp=%h", i, res, exp[i]); end
         checks++; if (lat != 35) begin errors++; $display("FAIL mulh_latency[%0d] got=%0d exp=35", i, lat); end
      end
   endtask

   task automatic test_div_rem();
      logic [2:0]  f3s [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      logic [31:0] res; int lat; bit s_ok, r_ok;
      for (int i = 0; i < 4; i++) begin
         do_op(f3s[i], as[i], bs[i], 1'b0, res, lat, s_ok, r_ok);
         checks++; if (res !== exp[i]) begin errors++; $display("FAIL divrem_result[%0d] got=%h exp=%h", i, res, exp[i]); end
         checks++; if (lat != 35) begin errors++; $display("FAIL divrem_latency[%0d] got=%0d exp=35", i, lat); end
      end
   endtask

   task automatic test_special();
      logic [2:0]  f3s [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
      logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF6};
      logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] res; int lat; bit s_ok, r_ok;
      for (int i = 0; i < 5; i++) begin
         do_op(f3s[i], as[i], bs[i], 1'b0, res, lat, s_ok, r_ok);
         checks++; if (res !== exp[i]) begin errors++; $display("FAIL special_result[%0d] got=%h exp=%h", i, res, exp[i]); end
         checks++; if (lat != 2) begin errors++; $display("FAIL special_latency[%0d] got=%0d exp=2", i, lat); end
         checks++; if (!s_ok) begin errors++; $display("FAIL special_stall[%0d] got=bad exp=high until done", i); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res1, res2; int lat1, lat2; bit s1, s2, r1, r2;
      do_op(3'b000, 32'd12345, 32'd678, 1'b1, res1, lat1, s1, r1);
      do_op(3'b000, 32'hFFFF_FFFF, 32'h0001_0001, 1'b0, res2, lat2, s2, r2);
      checks++; if (res1 !== 32'd8369910) begin errors++; $display("FAIL b2b_result1 got=%h exp=%h", res1, 32'd8369910); end
      checks++; if (res2 !== 32'hFFFE_FFFF) begin errors++; $display("FAIL b2b_result2 got=%h exp=fffeffff", res2); end
      checks++; if (!r2) begin errors++; $display("FAIL b2b_ready_after_done got=0 exp=1"); end
      checks++; if (lat1 != 35 || lat2 != 35)
         begin errors++; $display("FAIL b2b_latency got=%0d,%0d exp=35,35", lat1, lat2); end
      checks++; if (!s1 || !s2) begin errors++; $display("FAIL b2b_stall got=bad exp=high until each done"); end
   endtask

   task automatic test_flush();
      logic [31:0] res; int lat; bit s_ok, r_ok; bit saw_done;
      do_op(3'b000, 32'd6, 32'd7, 1'b0, res, lat, s_ok, r_ok);
      checks++; if (res !== 32'd42) begin errors++; $display("FAIL flush_setup_result got=%h exp=0000002a", res); end
      @(negedge clk);
      req_valid = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
      @(posedge clk);
      saw_done = 1'b0;
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      flush = 1'b1; req_valid = 1'b0;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got ready=%b exp=1", req_ready); end
      checks++; if (result !== 32'd42) begin errors++; $display("FAIL flush_result_held got=%h exp=0000002a", result); end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      checks++; if (saw_done) begin errors++; $display("FAIL flush_no_done got=pulse exp=none"); end
      // Flush on the accept edge: nothing may be latched.
      req_valid = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_accept_ready got=%b exp=1", req_ready); end
      saw_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      checks++; if (saw_done || result !== 32'd42)
         begin errors++; $display("FAIL flush_accept_ignored got done=%b result=%h exp done=0 result=0000002a", saw_done, result); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res; int lat; bit s_ok, r_ok;
      @(negedge clk);
      req_valid = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
      repeat (15) @(negedge clk);
      checks++; if (result === 32'h0) begin errors++; $display("FAIL reset_mid_precondition got=%h exp=nonzero", result); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1 || done !== 1'b0 || result !== 32'h0)
         begin errors++; $display("FAIL reset_mid_outputs got ready=%b done=%b result=%h exp 1 0 00000000", req_ready, done, result); end
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      do_op(3'b111, 32'd50, 32'd8, 1'b0, res, lat, s_ok, r_ok);
      checks++; if (res !== 32'd2 || lat != 35)
         begin errors++; $display("FAIL reset_mid_recover got result=%h lat=%0d exp 00000002 35", res, lat); end
   endtask

   task automatic test_random();
      logic [2:0] f3; logic [31:0] a, b, res; int lat; bit s_ok, r_ok;
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
         endcase
         do_op(f3, a, b, 1'b0, res, lat, s_ok, r_ok);
         checks++; if (res !== ref_model(f3, a, b))
            begin errors++; $display("FAIL rand_result f3=%0d a=%h b=%h got=%h exp=%h", f3, a, b, res, ref_model(f3, a, b)); end
         checks++; if (lat != ref_latency(f3, a, b))
            begin errors++; $display("FAIL rand_latency f3=%0d a=%h b=%h got=%0d exp=%0d", f3, a, b, lat, ref_latency(f3, a, b)); end
         checks++; if (!s_ok || !r_ok)
            begin errors++; $display("FAIL rand_handshake f3=%0d stall_ok=%b ready_ok=%b exp 1 1", f3, s_ok, r_ok); end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div_rem();
      test_special();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the single-cycle ALU.
- Accepts one operation, iterates a shared shift/add-subtract datapath for XLEN cycles, then returns a result.
- Holds the core's stall line so PC and register-file writes freeze until the result is ready.

Parameters:
- XLEN, 32, operand/result width; must be a power of two and at least 8.
- CW, log2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  core clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  M-extension instruction present (opcode 0110011 with funct7 0000001).
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- flush  input  1  abort any in-flight operation.
- req_ready  output  1  high only in IDLE.
- stall  output  1  combinational: req_valid & ~done.
- done  output  1  one-cycle pulse; result is valid this cycle.
- result  output  XLEN  registered result; held until the next accept.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, req_ready=1, done=0, result=0, counter=0, internal accumulators=0.
- Accept: req_valid & req_ready at a rising edge. On accept, latch funct3, operand signs, and absolute values.
  - Signed inputs: MULH both operands; MULHSU op_a only; DIV/REM both.
- States:
  - IDLE: on accept, go to PREP.
  - PREP (1 cycle): special-case check.
    - Divide by zero: quotient = all ones; remainder = op_a. Go to DONE.
    - Signed overflow (op_a = 2^(XLEN-1), op_b = -1, DIV/REM): quotient = op_a; remainder = 0. Go to DONE.
    - Otherwise load counter=XLEN and go to CALC.
  - CALC (XLEN cycles): one iteration per cycle; counter decrements; at counter=1, go to FIX.
    - Multiply: shift-add on a 2*XLEN product register.
    - Divide: restoring divide, shifting the remainder/quotient pair.
  - FIX (1 cycle): negate the product if operand signs differ; negate the quotient if signs differ; the remainder takes the dividend's sign. Go to DONE.
  - DONE (1 cycle): done=1, result register loaded, then go to IDLE.
    - MUL selects product[XLEN-1:0]; MULH/MULHSU/MULHU select product[2XLEN-1:XLEN].
    - DIV/DIVU select the quotient; REM/REMU select the remainder.
- Latency, accept edge to done:
  - Normal operation: XLEN+3 cycles (35 at XLEN=32).
  - Special case: 2 cycles.
- Stall: high from the cycle req_valid rises until the done cycle inclusive, minus that cycle. The core advances on the edge ending the done cycle.
- req_valid held high while in DONE: no re-accept that cycle, because req_ready=0 there.
  - The next accept happens in IDLE only after the core moves on.
  - If the following instruction is also M-type, it is accepted one cycle later.
- flush: synchronous, highest priority after reset.
  - Forces IDLE on the next edge; done is not pulsed; result is unchanged.
  - flush coincident with an accept: flush wins and nothing is latched.
- funct3 and op_a/op_b are ignored outside the accept edge; changes mid-operation have no effect.
- All arithmetic is on unsigned magnitudes; two's-complement negation wraps modulo 2^XLEN.

Decomposition:
- Shared package holds:
  - M-extension funct3 constants (MUL..REMU) and the M funct7 value 0000001.
  - State encoding: IDLE, PREP, CALC, FIX, DONE as 3-bit localparams.
- One sub-module is natural: muldiv_iter_step.
  - Combinational single-iteration datapath: one shift-add or one restoring subtract step.
  - The sequencer owns all registers and the FSM.

Test Plan:
- MUL: op_a=7, op_b=-3 (0xFFFFFFFD) -> done after 35 cycles, result=0xFFFFFFEB, stall high for the 35 cycles preceding done.
- MULH / MULHU: op_a=0x80000000, op_b=0x80000000 -> MULH result=0x40000000; MULHU result=0x40000000. MULHSU op_a=-1, op_b=2 -> 0xFFFFFFFF.
- DIV / REM signs: op_a=-7, op_b=2 -> DIV=0xFFFFFFFD (-3), REM=0xFFFFFFFF (-1). DIVU op_a=100, op_b=7 -> 14; REMU -> 2.
- Special cases: DIVU by 0 with op_a=5 -> result=0xFFFFFFFF, done 2 cycles after accept. REM by 0 -> 5. DIV 0x80000000 by -1 -> 0x80000000; REM of the same -> 0.
- Back-to-back: two MULs with req_valid held -> second accepted exactly one cycle after the first done, both results correct, no double accept.
- Abort and reset:
  - flush asserted at CALC cycle 10 -> IDLE next edge, no done pulse, result retains its prior value.
  - reset_n pulsed low mid-CALC -> outputs immediately at reset values (req_ready=1, done=0, result=0).
